seq_serializer: RTL
===================

# seq_serializer

Parallel-to-serial front end for the sequence-detector chain. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line. That line drives the detector's `in` input directly. Between frames the line holds a fixed idle level, and a programmable inter-frame gap keeps frames separated.

## Interface
- `WIDTH`, 8: bits per frame; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- `GAP_CYCLES`, 2: idle-level cycles inserted after each frame; legal range 0..15.
- `IDLE_BIT`, 1'b1: serial level driven whenever no frame bit is being sent.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  WIDTH  parallel word to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `flush`  in  1  synchronous abort of the current frame/gap.
- `ser_out`  out  1  serial bit stream to the detector.
- `ser_valid`  out  1  high while `ser_out` carries a frame bit.
- `frame_done`  out  1  one-cycle pulse with the last bit of a frame.
- `busy`  out  1  high in SHIFT or GAP.
- `frame_cnt`  out  16  frames fully sent since reset; wraps.

## Operation
- FSM states: IDLE, SHIFT, GAP. All outputs are registered except `in_ready` and `busy`, which decode the state.
- IDLE:
  - `in_ready`=1, `ser_out`=IDLE_BIT, `ser_valid`=0.
  - On `in_valid`&&`in_ready`: load `in_data` into the shift register, set the bit counter to 0, go to SHIFT.
- SHIFT:
  - `in_ready`=0.
  - Each cycle: `ser_out` = current head bit (MSB when MSB_FIRST=1, else LSB), `ser_valid`=1.
  - The shift register shifts toward the head, and the bit counter increments (width $clog2(WIDTH)).
  - On the cycle the bit counter reads WIDTH-1:
    - `frame_done`=1 and `frame_cnt` increments.
    - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - `ser_out`=IDLE_BIT, `ser_valid`=0, `in_ready`=0.
  - The gap counter runs 0..GAP_CYCLES-1, then the FSM goes to IDLE.
- `flush`: in any state, next state is IDLE.
  - `ser_out`=IDLE_BIT, `ser_valid`=0 from the next cycle onward.
  - The shift register and counters clear.
  - `frame_done` does not pulse and `frame_cnt` does not increment, even if `flush` coincides with the last bit.
  - `flush` in IDLE takes priority over `in_valid`: the word is not accepted (`in_ready` is forced 0 while `flush`=1).
- `frame_cnt` wraps from 16'hFFFF to 16'h0000 with no flag.
- `in_data` is sampled only at acceptance. Later changes to `in_data` have no effect on the frame in flight.

## Timing
- Reset (`rst`=0, asynchronous) gives:
  - state IDLE
  - `ser_out`=IDLE_BIT, `ser_valid`=0, `frame_done`=0
  - `frame_cnt`=0, shift register 0
  - `in_ready`=1 after reset, `busy`=0
- Reset deasserting mid-frame is a plain restart: no partial bits resume.
- Acceptance at edge k:
  - First frame bit appears on `ser_out` in cycle k+1.
  - Last bit appears in cycle k+WIDTH, with `frame_done`=1 in that same cycle.
- GAP occupies cycles k+WIDTH+1 .. k+WIDTH+GAP_CYCLES.
- `in_ready` rises in cycle k+WIDTH+GAP_CYCLES+1.
- Maximum throughput: one frame per WIDTH+GAP_CYCLES+1 cycles.
- With GAP_CYCLES=0, consecutive frames are separated by exactly one IDLE cycle at IDLE_BIT.
- `flush` sampled at edge j: `ser_out`=IDLE_BIT from cycle j+1, and `in_ready`=1 in cycle j+1 if `flush` has dropped.

## Test plan
- Reset and idle: hold `rst`=0 for 3 cycles, then release with `in_valid`=0 for 10 cycles → `ser_out`=1, `ser_valid`=0, `in_ready`=1, `frame_cnt`=0 throughout.
- MSB-first frame: WIDTH=8, GAP=2, accept 8'h35 at edge k →
  - `ser_out` 0,0,1,1,0,1,0,1 in cycles k+1..k+8
  - `frame_done` high only at k+8
  - `ser_out`=1 at k+9..k+10
  - `in_ready` high at k+11
  - `frame_cnt`=1
- LSB-first with the detector attached: MSB_FIRST=0, accept 8'hAA → `ser_out` 0,1,0,1,0,1,0,1; the downstream 0101 detector pulses its output on the 4th and 6th and 8th bits.
- Back-to-back with GAP=0: `in_valid` held high with words 8'hFF then 8'h00 →
  - 8 ones, one idle cycle, then 8 zeros
  - second acceptance exactly 9 cycles after the first
  - `frame_cnt`=2
- Flush on the last bit: assert `flush` in the cycle `ser_valid` carries bit 7 → no `frame_done`, `frame_cnt` unchanged, `ser_out`=1 and `ser_valid`=0 the next cycle, `in_ready`=1 once `flush` is low.
- Counter wrap: preload via 65535 frames (or force), send one more frame → `frame_cnt` goes 16'hFFFF → 16'h0000 on that frame's `frame_done`.

Source files
------------

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end with a valid/ready intake, selectable
// bit order, a fixed idle level between frames and a programmable inter-frame gap.
module seq_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int              CntW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit   = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PenultBit = CntW'(WIDTH - 2);
  localparam logic [3:0]      LastGap   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  function automatic logic head_of(logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // The output register holds the bit on the line, so the shift register always
  // carries the bits not yet sent; it is loaded already advanced by one.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_out_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (flush) begin
      state_d   = StIdle;
      sreg_d    = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_d     = StShift;
            sreg_d      = advance(in_data);
            bit_cnt_d   = '0;
            ser_out_d   = head_of(in_data);
            ser_valid_d = 1'b1;
          end
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            bit_cnt_d   = '0;
            gap_cnt_d   = '0;
            state_d     = (GAP_CYCLES > 0) ? StGap : StIdle;
          end else begin
            ser_out_d   = head_of(sreg_q);
            ser_valid_d = 1'b1;
            sreg_d      = advance(sreg_q);
            bit_cnt_d   = bit_cnt_q + 1'b1;
            done_d      = (bit_cnt_q == PenultBit);
          end
        end
        StGap: begin
          if (gap_cnt_q == LastGap) begin
            state_d   = StIdle;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready   = (state_q == StIdle) && !flush;
  assign busy       = (state_q != StIdle);
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  // An abort landing on the last bit must swallow the already-registered pulse.
  assign frame_done = done_q && !flush;
  assign frame_cnt  = frame_cnt_q;

endmodule
